// File: rtl/alu_bit_slice.sv
// alu_bit_slice: WIDTH-bit ripple-carry ALU built from 1-bit slices, with result and flags registered (1-cycle latency).
module alu_bit_slice #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res_c;
  logic             cy;
  logic             cin_msb;
  logic             real_b;
  // The carry ripples through a loop variable so the chain stays in one block.
  always_comb begin
    sum     = '0;
    cy      = cntrl[0];
    cin_msb = 1'b0;
    real_b  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      real_b  = cntrl[0] ? ~B[k] : B[k];
      cin_msb = cy;
      sum[k]  = A[k] ^ real_b ^ cy;
      cy      = (A[k] & real_b) | (cy & (A[k] ^ real_b));
    end
  end
  // Logic ops use the unmodified B, never the muxed adder input.
  always_comb begin
    res_c = cntrl[2] ? (cntrl[1] ? (cntrl[0] ? '0 : A ^ B) : (cntrl[0] ? A | B : A & B))
                     : (cntrl[1] ? sum : (cntrl[0] ? '0 : B));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      result    <= res_c;
      negative  <= res_c[WIDTH-1];
      zero      <= (res_c == '0);
      overflow  <= cin_msb ^ cy;
      carry_out <= cy;
    end
  end
endmodule

// File: tb/tb_alu_bit_slice.sv
// tb_alu_bit_slice: directed vector table, reset sequences and back-to-back random throughput check.
module tb_alu_bit_slice;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] A, B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative, zero, overflow, carry_out;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs [12];

  alu_bit_slice #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .cntrl(cntrl),
    .result(result), .negative(negative), .zero(zero),
    .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference built from wide arithmetic and sign-based overflow.
  function automatic logic [67:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] bb, r;
    logic        v;
    bb = op[0] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {64'd0, op[0]};
    v  = (a[63] == bb[63]) && (s[63] != a[63]);
    case (op)
      3'b000:  r = b;
      3'b010,
      3'b011:  r = s[63:0];
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      default: r = '0;
    endcase
    return {r, r[63], r == 64'd0, v, s[64]};
  endfunction

  task automatic step(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    cntrl = op; A = a; B = b;
    @(posedge clk); #1;
  endtask

  initial begin
    // flags field is {negative, zero, overflow, carry_out}
    vecs[0]  = '{3'b000, 64'hFFFF, 64'h1234, 64'h1234, 4'b0000};
    vecs[1]  = '{3'b001, 64'hFFFF, 64'h1234, 64'h0, 4'b0101};
    vecs[2]  = '{3'b111, 64'hFFFF, 64'h1234, 64'h0, 4'b0101};
    vecs[3]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0101};
    vecs[4]  = '{3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1010};
    vecs[5]  = '{3'b011, 64'h5, 64'h5, 64'h0, 4'b0101};
    vecs[6]  = '{3'b011, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[7]  = '{3'b011, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[8]  = '{3'b100, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000};
    vecs[9]  = '{3'b101, 64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000};
    vecs[10] = '{3'b110, 64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000};
    vecs[11] = '{3'b110, 64'h1, 64'h1, 64'h0, 4'b0100};

    reset = 1'b1;
    step(3'b010, 64'd1, 64'd1);
    check("reset_result", result, 64'd0);
    check("reset_flags", {60'd0, negative, zero, overflow, carry_out}, 64'd0);
    step(3'b010, 64'd1, 64'd1);
    check("reset_held_result", result, 64'd0);
    reset = 1'b0;
    step(3'b010, 64'd1, 64'd1);
    check("post_reset_result", result, 64'd2);
    check("post_reset_flags", {60'd0, negative, zero, overflow, carry_out}, 64'd0);
    step(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("pre_mid_reset_flags", {60'd0, negative, zero, overflow, carry_out}, 64'hA);
    reset = 1'b1;
    step(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("mid_reset_result", result, 64'd0);
    check("mid_reset_flags", {60'd0, negative, zero, overflow, carry_out}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_result", i), result, vecs[i].r);
      check($sformatf("vec%0d_flags", i), {60'd0, negative, zero, overflow, carry_out}, {60'd0, vecs[i].f});
    end

    begin
      logic [67:0] exp;
      logic [2:0]  pop;
      logic [63:0] pa, pb;
      pop = 3'd0; pa = {$urandom, $urandom}; pb = {$urandom, $urandom};
      step(pop, pa, pb);
      for (int i = 1; i <= 64; i++) begin
        exp = model(pop, pa, pb);
        check($sformatf("tp%0d_result", i), result, exp[67:4]);
        check($sformatf("tp%0d_flags", i), {60'd0, negative, zero, overflow, carry_out}, {60'd0, exp[3:0]});
        pop = 3'(i % 8);
        pa  = (i % 5 == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
        pb  = (i % 7 == 0) ? pa : {$urandom, $urandom};
        step(pop, pa, pb);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
